conv_output_stream: RTL and testbench

CONV_OUTPUT_STREAM -- requirements
Module: conv_output_stream

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_out_fifo.sv | 54 +++++
 rtl/conv_output_stream.sv | 180 ++++++++++++++++++
 tb/tb_conv_output_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output stream: FSM states, lane width
// and the ceiling-divide helper used to size channel groups.
package conv_pkg;

   localparam int LANE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
      return (num + den - 32'd1) / den;
   endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous output buffer holding packed beats with their framing flags.
// The head word reads as zero while the buffer is empty.
module conv_out_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wrData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdData_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   assign doPush   = push_i && !full_o;
   assign doPop    = pop_i && !empty_o;
   assign full_o   = (count_q == (AW+1)'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign rdData_o = empty_o ? '0 : mem[rdPtr_q];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr_q] <= wrData_i;
   end

endmodule

// File: rtl/conv_output_stream.sv
// Packs systolic-array results into framed int8 beats (rowEnd/last) for one layer.
// Optional CONV_OUTPUT_RELU_EN clamps negative lanes to zero before buffering.
module conv_output_stream
   import conv_pkg::*;
#(
   parameter int LANES      = 8,
   parameter int DIM_W      = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [DIM_W-1:0]        In_Channel,
   input  logic [DIM_W-1:0]        Matrix_Col,
   input  logic [DIM_W-1:0]        Matrix_Row,
   input  logic [LANE_W*LANES-1:0] sData,
   input  logic                    sValid,
   output logic                    sReady,
   output logic [LANE_W*LANES-1:0] mData_payload,
   output logic                    mData_valid,
   input  logic                    mData_ready,
   output logic                    mData_last,
   output logic                    mData_rowEnd,
   output logic                    layer_done
);

   localparam int DATA_W = LANE_W * LANES;
   localparam int FIFO_W = DATA_W + 2;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   state_e            state_q, state_d;
   logic [DIM_W-1:0]  groups_q, groups_d;
   logic [DIM_W-1:0]  rem_q, rem_d;
   logic [DIM_W-1:0]  cols_q, cols_d;
   logic [DIM_W-1:0]  rows_q, rows_d;
   logic [DIM_W-1:0]  grpCnt_q, grpCnt_d;
   logic [DIM_W-1:0]  colCnt_q, colCnt_d;
   logic [DIM_W-1:0]  rowCnt_q, rowCnt_d;
   logic              layerDone_q, layerDone_d;

   logic              accept;
   logic              lastGroup;
   logic              lastCol;
   logic              lastRow;
   logic              beatRowEnd;
   logic              beatLast;
   logic [DATA_W-1:0] beatData;
   logic [LANE_W-1:0] laneVal;

   logic              fifoFull;
   logic              fifoEmpty;
   logic [CNT_W-1:0]  fifoCount;
   logic [FIFO_W-1:0] fifoRdData;

   assign sReady     = (state_q == RUN) && !fifoFull;
   assign accept     = sValid && sReady;
   assign lastGroup  = (grpCnt_q == groups_q - DIM_W'(1));
   assign lastCol    = (colCnt_q == cols_q - DIM_W'(1));
   assign lastRow    = (rowCnt_q == rows_q - DIM_W'(1));
   assign beatRowEnd = lastGroup && lastCol;
   assign beatLast   = beatRowEnd && lastRow;
   assign layer_done = layerDone_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         groups_q    <= '0;
         rem_q       <= '0;
         cols_q      <= '0;
         rows_q      <= '0;
         grpCnt_q    <= '0;
         colCnt_q    <= '0;
         rowCnt_q    <= '0;
         layerDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         groups_q    <= groups_d;
         rem_q       <= rem_d;
         cols_q      <= cols_d;
         rows_q      <= rows_d;
         grpCnt_q    <= grpCnt_d;
         colCnt_q    <= colCnt_d;
         rowCnt_q    <= rowCnt_d;
         layerDone_q <= layerDone_d;
      end
   end

   // Counters walk channel group fastest, then column, then row.
   always_comb begin
      state_d     = state_q;
      groups_d    = groups_q;
      rem_d       = rem_q;
      cols_d      = cols_q;
      rows_d      = rows_q;
      grpCnt_d    = grpCnt_q;
      colCnt_d    = colCnt_q;
      rowCnt_d    = rowCnt_q;
      layerDone_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if ((In_Channel == '0) || (Matrix_Col == '0) || (Matrix_Row == '0)) begin
                  layerDone_d = 1'b1;
               end else begin
                  state_d  = RUN;
                  groups_d = DIM_W'(ceil_div(32'(In_Channel), 32'(LANES)));
                  rem_d    = DIM_W'(32'(In_Channel) % 32'(LANES));
                  cols_d   = Matrix_Col;
                  rows_d   = Matrix_Row;
                  grpCnt_d = '0;
                  colCnt_d = '0;
                  rowCnt_d = '0;
               end
            end
         end
         RUN: begin
            if (accept) begin
               if (!lastGroup) begin
                  grpCnt_d = grpCnt_q + DIM_W'(1);
               end else begin
                  grpCnt_d = '0;
                  if (!lastCol) begin
                     colCnt_d = colCnt_q + DIM_W'(1);
                  end else begin
                     colCnt_d = '0;
                     if (!lastRow) begin
                        rowCnt_d = rowCnt_q + DIM_W'(1);
                     end else begin
                        rowCnt_d = '0;
                        state_d  = DRAIN;
                     end
                  end
               end
            end
         end
         DRAIN: begin
            if (fifoCount == '0) begin
               state_d     = IDLE;
               layerDone_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Lanes beyond the real channel count in the final group are padding.
   always_comb begin
      beatData = '0;
      laneVal  = '0;
      for (int i = 0; i < LANES; i++) begin
         laneVal = sData[i*LANE_W +: LANE_W];
`ifdef CONV_OUTPUT_RELU_EN
         if (laneVal[LANE_W-1]) laneVal = '0;
`else
         laneVal = laneVal;
`endif
         if (lastGroup && (rem_q != '0) && (rem_q <= DIM_W'(i))) laneVal = '0;
         beatData[i*LANE_W +: LANE_W] = laneVal;
      end
   end

   conv_out_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_i   (accept),
      .wrData_i ({beatLast, beatRowEnd, beatData}),
      .pop_i    (mData_valid && mData_ready),
      .rdData_o (fifoRdData),
      .full_o   (fifoFull),
      .empty_o  (fifoEmpty),
      .count_o  (fifoCount)
   );

   assign mData_valid = !fifoEmpty;
   assign {mData_last, mData_rowEnd, mData_payload} = fifoRdData;

endmodule

// File: tb/tb_conv_output_stream.sv
// Self-checking bench for conv_output_stream: table of layers plus random layers,
// each beat compared against an index-based arithmetic model of the packing rules.
module tb_conv_output_stream;

   localparam int L  = 8;
   localparam int DW = 8 * L;

   logic          clk;
   logic          reset;
   logic          start;
   logic [15:0]   In_Channel, Matrix_Col, Matrix_Row;
   logic [DW-1:0] sData;
   logic          sValid, sReady;
   logic [DW-1:0] mData_payload;
   logic          mData_valid, mData_ready, mData_last, mData_rowEnd, layer_done;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] inData [];

   typedef struct {
      int ic; int col; int row;
      int validPct; int readyPct;
      int hold; int expHeld; int abortAt;
      int dataMode; int expBeats;
   } vec_t;

   vec_t tbl [8];

   conv_output_stream dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .In_Channel    (In_Channel),
      .Matrix_Col    (Matrix_Col),
      .Matrix_Row    (Matrix_Row),
      .sData         (sData),
      .sValid        (sValid),
      .sReady        (sReady),
      .mData_payload (mData_payload),
      .mData_valid   (mData_valid),
      .mData_ready   (mData_ready),
      .mData_last    (mData_last),
      .mData_rowEnd  (mData_rowEnd),
      .layer_done    (layer_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Expected beat k, derived from its position in the layer and the raw input word.
   function automatic logic [DW+1:0] modelBeat(input int k, input int ic, input int col,
                                                input int total, input logic [DW-1:0] raw);
      int g, nv, grp;
      logic [7:0] b;
      logic [DW-1:0] o;
      grp = (ic + L - 1) / L;
      g   = k % grp;
      nv  = ic - g * L;
      if (nv > L) nv = L;
      o = '0;
      for (int i = 0; i < L; i++) begin
         b = raw[i*8 +: 8];
`ifdef CONV_OUTPUT_RELU_EN
         if ($signed(b) < 0) b = 8'h00;
`endif
         if (i >= nv) b = 8'h00;
         o[i*8 +: 8] = b;
      end
      return {(k == total - 1), (((k + 1) % (grp * col)) == 0), o};
   endfunction

   task automatic applyReset();
      reset = 1'b0; start = 1'b0; sValid = 1'b0; mData_ready = 1'b0; sData = '0;
      @(negedge clk);
      checkOutput("reset_sReady",   128'(sReady),       128'(0));
      checkOutput("reset_valid",    128'(mData_valid),  128'(0));
      checkOutput("reset_last",     128'(mData_last),   128'(0));
      checkOutput("reset_rowEnd",   128'(mData_rowEnd), 128'(0));
      checkOutput("reset_done",     128'(layer_done),   128'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_valid", 128'(mData_valid), 128'(0));
   endtask

   task automatic applyStimulus(input vec_t v, output logic [DW+1:0] firstBeat,
                                output logic [DW+1:0] lastBeat);
      int grp, total, inIdx, outIdx, doneCnt, cyc, limit, tail;
      logic [DW+1:0] got, prevHead;
      logic [7:0] pat [4];
      bit prevStall, acc, pop;
      pat[0] = 8'h80; pat[1] = 8'h7F; pat[2] = 8'hFF; pat[3] = 8'h01;
      grp   = (v.ic + L - 1) / L;
      total = v.row * v.col * grp;
      inData = new[total];
      for (int k = 0; k < total; k++) begin
         for (int i = 0; i < L; i++) begin
            case (v.dataMode)
               1:       inData[k][i*8 +: 8] = 8'hFF;
               2:       inData[k][i*8 +: 8] = pat[i % 4];
               default: inData[k][i*8 +: 8] = 8'($urandom);
            endcase
         end
      end
      firstBeat = '0; lastBeat = '0;
      @(posedge clk); #1;
      In_Channel = 16'(v.ic); Matrix_Col = 16'(v.col); Matrix_Row = 16'(v.row);
      start = 1'b1; sValid = 1'b0; mData_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      inIdx = 0; outIdx = 0; doneCnt = 0; cyc = 0; tail = 0; prevStall = 0; prevHead = '0;
      limit = total * 12 + 300 + v.hold;
      sValid = ($urandom_range(99) < 32'(v.validPct));
      sData  = inData[0];
      mData_ready = (v.hold > 0) ? 1'b0 : ($urandom_range(99) < 32'(v.readyPct));
      while (1) begin
         @(negedge clk);
         acc = sValid && sReady;
         pop = mData_valid && mData_ready;
         got = {mData_last, mData_rowEnd, mData_payload};
         if (prevStall) checkOutput("stall_stable", 128'(got), 128'(prevHead));
         if (pop) begin
            if (outIdx < total) begin
               checkOutput($sformatf("beat%0d", outIdx), 128'(got),
                           128'(modelBeat(outIdx, v.ic, v.col, total, inData[outIdx])));
               if (outIdx == 0) firstBeat = got;
               lastBeat = got;
            end else begin
               checkOutput("extra_beat", 128'(outIdx), 128'(total - 1));
            end
            outIdx++;
         end
         if (layer_done) doneCnt++;
         prevStall = mData_valid && !mData_ready;
         prevHead  = got;
         if (v.hold > 0 && cyc == v.hold - 1) begin
            checkOutput("held_beats",  128'(inIdx + int'(acc)), 128'(v.expHeld));
            checkOutput("held_sReady", 128'(sReady),            128'(0));
         end
         if (v.abortAt > 0 && inIdx >= v.abortAt) break;
         if (doneCnt > 0) tail++;
         if (tail >= 4) break;
         cyc++;
         if (cyc > limit) begin
            checkOutput("timeout_beats_out", 128'(outIdx), 128'(total));
            break;
         end
         @(posedge clk); #1;
         if (acc) inIdx++;
         sValid = (inIdx < total) && ($urandom_range(99) < 32'(v.validPct));
         sData  = (inIdx < total) ? inData[inIdx] : '0;
         mData_ready = (cyc < v.hold) ? 1'b0 : ($urandom_range(99) < 32'(v.readyPct));
      end
      sValid = 1'b0;
      if (v.abortAt == 0) begin
         checkOutput("beats_out",   128'(outIdx),  128'(v.expBeats));
         checkOutput("beats_in",    128'(inIdx),   128'(v.expBeats));
         checkOutput("done_pulses", 128'(doneCnt), 128'(1));
      end
   endtask

   task automatic zeroDimTest();
      @(posedge clk); #1;
      In_Channel = 16'd8; Matrix_Col = 16'd3; Matrix_Row = 16'd0;
      start = 1'b1; sValid = 1'b1; mData_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("zero_done",   128'(layer_done), 128'(1));
      checkOutput("zero_sReady", 128'(sReady),     128'(0));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("zero_sReady_hold", 128'(sReady),     128'(0));
         checkOutput("zero_done_once",   128'(layer_done), 128'(0));
      end
      sValid = 1'b0;
   endtask

   initial begin
      logic [DW+1:0] fb, lb;
      vec_t rv;
      int grp;
      reset = 1'b1; start = 1'b0; sValid = 1'b0; mData_ready = 1'b0; sData = '0;
      In_Channel = '0; Matrix_Col = '0; Matrix_Row = '0;
      #1;
      applyReset();

      //           ic col row  vPct rPct hold held abort mode beats
      tbl[0] = '{32, 14, 14, 100, 100, 0,  0,  0,   0,   784};
      tbl[1] = '{12, 2,  1,  100, 100, 0,  0,  0,   1,   4};
      tbl[2] = '{20, 3,  4,  70,  60,  0,  0,  0,   0,   36};
      tbl[3] = '{5,  1,  1,  100, 100, 0,  0,  0,   0,   1};
      tbl[4] = '{17, 4,  3,  100, 100, 40, 16, 0,   0,   36};
      tbl[5] = '{8,  1,  1,  100, 100, 0,  0,  0,   2,   1};
      tbl[6] = '{32, 14, 14, 100, 100, 0,  0,  100, 0,   784};
      tbl[7] = '{32, 14, 14, 80,  80,  0,  0,  0,   0,   784};

      for (int t = 0; t < 8; t++) begin
         applyStimulus(tbl[t], fb, lb);
         if (tbl[t].abortAt > 0) applyReset();
         if (t == 1) checkOutput("partial_group_last", 128'(lb), 128'({2'b11, 64'h00000000FFFFFFFF}));
         if (t == 5) begin
`ifdef CONV_OUTPUT_RELU_EN
            checkOutput("relu_lanes", 128'(fb[31:0]), 128'(32'h01007F00));
`else
            checkOutput("pass_lanes", 128'(fb[31:0]), 128'(32'h01FF7F80));
`endif
         end
      end

      zeroDimTest();

      for (int n = 0; n < 4; n++) begin
         rv.ic = int'($urandom_range(40, 1)); rv.col = int'($urandom_range(5, 1));
         rv.row = int'($urandom_range(4, 1));
         rv.validPct = int'($urandom_range(100, 30)); rv.readyPct = int'($urandom_range(100, 30));
         rv.hold = 0; rv.expHeld = 0; rv.abortAt = 0; rv.dataMode = 0;
         grp = (rv.ic + L - 1) / L;
         rv.expBeats = rv.row * rv.col * grp;
         applyStimulus(rv, fb, lb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
